// File: rtl/replica_pkg.sv
// replica_pkg: shared annealer replica types and sizing, including the distance-table loader states.
package replica_pkg;
  typedef logic [15:0] distance_data_t;
  localparam int city_num = 8;
  localparam int city_num_log = 3;
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} loader_state_t;
endpackage

// File: rtl/tp_dis_loader.sv
// tp_dis_loader: unpacks 64-bit stream words into row-major N x N distance-table writes.
module tp_dis_loader
  import replica_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [city_num_log:0]     city_count,
  input  logic                      running,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_valid,
  input  logic [63:0]               s_data,
  output logic                      s_ready,
  output logic                      tp_dis_write,
  output logic [city_num_log*2-1:0] tp_dis_waddr,
  output distance_data_t            tp_dis_wdata
);
  localparam int W = $bits(distance_data_t);
  localparam int LANES = 64 / W;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int RW = city_num_log;
  localparam int NW = city_num_log + 1;
  localparam int CW = city_num_log * 2 + 1;
  if (64 % W != 0) begin : g_lanes_check
    $error("distance_data_t width must divide 64");
  end
  loader_state_t state, state_n;
  distance_data_t [LANES-1:0] word, word_n;
  logic [LW-1:0] lane, lane_n;
  logic [RW-1:0] row, row_n, col, col_n;
  logic [NW-1:0] n, n_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last, lane_end, col_end, load_ok;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    load_ok = start && !running && city_count >= NW'(2) && city_count <= NW'(city_num);
    last = (cnt + CW'(1)) == CW'(n) * CW'(n);
    lane_end = lane == LW'(LANES - 1);
    col_end = {1'b0, col} == n - NW'(1);
    s_ready = state == FETCH || (state == EMIT && lane_end && !last);
    state_n = state;
    word_n = word;
    lane_n = lane;
    row_n = row;
    col_n = col;
    n_n = n;
    cnt_n = cnt;
    unique case (state)
      IDLE: if (load_ok) begin
        n_n = city_count;
        row_n = '0;
        col_n = '0;
        cnt_n = '0;
        state_n = FETCH;
      end
      FETCH: if (s_valid) begin
        word_n = s_data;
        lane_n = '0;
        state_n = EMIT;
      end
      EMIT: begin
        cnt_n = cnt + CW'(1);
        col_n = col_end ? '0 : col + RW'(1);
        row_n = col_end ? row + RW'(1) : row;
        // a word's leftover lanes are dropped once the final entry is written
        if (last) state_n = DONE;
        else if (!lane_end) lane_n = lane + LW'(1);
        else if (s_valid) begin
          word_n = s_data;
          lane_n = '0;
        end else state_n = FETCH;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // write outputs are registered from next-state values so a word's lane 0 lands one cycle after its handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word <= '0;
      lane <= '0;
      row <= '0;
      col <= '0;
      n <= '0;
      cnt <= '0;
      tp_dis_write <= 1'b0;
      tp_dis_waddr <= '0;
      tp_dis_wdata <= '0;
    end else begin
      state <= state_n;
      word <= word_n;
      lane <= lane_n;
      row <= row_n;
      col <= col_n;
      n <= n_n;
      cnt <= cnt_n;
      tp_dis_write <= state_n == EMIT;
      tp_dis_waddr <= {row_n, col_n};
      tp_dis_wdata <= word_n[lane_n];
    end
  end
endmodule

// File: tb/tb_tp_dis_loader.sv
// tb_tp_dis_loader: directed checks of the distance-table loader with hand-derived write sequences.
module tb_tp_dis_loader;
  logic clk = 1'b0;
  logic reset, start, running, s_valid, s_ready, busy, done, tp_dis_write;
  logic [3:0] city_count;
  logic [63:0] s_data;
  logic [5:0] tp_dis_waddr;
  logic [15:0] tp_dis_wdata;
  int vectors = 0, miscompares = 0;
  int n = 1, nn = 0, e = 0, widx = 0, ndone = 0, done_at = 0, c = 0;

  tp_dis_loader dut (
    .clk(clk), .reset(reset), .start(start), .city_count(city_count), .running(running),
    .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .tp_dis_write(tp_dis_write), .tp_dis_waddr(tp_dis_waddr), .tp_dis_wdata(tp_dis_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int k);
    return {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic hs;
    hs = s_valid && s_ready;
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      widx++;
      s_data = mk(widx);
    end
    c++;
    if (tp_dis_write) begin
      chk("extra_write", 64'(e < nn), 64'(1));
      chk("waddr", 64'(tp_dis_waddr), 64'((e / n) * 8 + e % n));
      chk("wdata", 64'(tp_dis_wdata), 64'(e + 1));
      e++;
    end
    if (done) begin
      ndone++;
      done_at = c;
    end
  endtask

  task automatic begin_load(input int n_in);
    n = n_in; nn = n * n; e = 0; widx = 0; ndone = 0; done_at = 0; c = 0;
    s_data = mk(0); s_valid = 1'b1; city_count = 4'(n_in); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load(input int n_in, input bit toggle, input int restart_at);
    begin_load(n_in);
    chk("busy_fetch", 64'(busy), 64'(1));
    chk("ready_fetch", 64'(s_ready), 64'(1));
    for (int i = 0; i < 200 && !(ndone > 0 && c > done_at + 3); i++) begin
      if (toggle) s_valid = ~s_valid;
      start = (c == restart_at);
      cyc();
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("write_count", 64'(e), 64'(nn));
    chk("done_count", 64'(ndone), 64'(1));
    chk("words_taken", 64'(widx), 64'((nn + 3) / 4));
    if (!toggle) chk("done_cycle", 64'(done_at), 64'(2 + nn));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ready"}, 64'(s_ready), 64'(0));
    chk({tag, "_write"}, 64'(tp_dis_write), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; running = 1'b0; s_valid = 1'b1; s_data = mk(0); city_count = 4'd4;
    cyc();
    cyc();
    idle_checks("reset");
    chk("reset_waddr", 64'(tp_dis_waddr), 64'(0));
    chk("reset_wdata", 64'(tp_dis_wdata), 64'(0));
    reset = 1'b0;
    s_valid = 1'b0;
    cyc();
    load(4, 1'b0, -1);
    load(3, 1'b0, -1);
    load(4, 1'b1, -1);
    running = 1'b1; city_count = 4'd4; start = 1'b1; s_valid = 1'b1; e = 0; nn = 0;
    cyc();
    start = 1'b0;
    cyc();
    idle_checks("running");
    running = 1'b0; city_count = 4'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    idle_checks("count1");
    city_count = 4'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    idle_checks("count9");
    s_valid = 1'b0;
    begin_load(4);
    for (int i = 0; i < 50 && e < 6; i++) cyc();
    chk("pre_reset_writes", 64'(e), 64'(6));
    reset = 1'b1;
    cyc();
    idle_checks("mid_reset");
    chk("mid_reset_waddr", 64'(tp_dis_waddr), 64'(0));
    chk("mid_reset_wdata", 64'(tp_dis_wdata), 64'(0));
    reset = 1'b0;
    s_valid = 1'b0;
    cyc();
    chk("mid_reset_no_done", 64'(ndone), 64'(0));
    chk("mid_reset_stays_idle", 64'(busy), 64'(0));
    load(4, 1'b0, -1);
    load(4, 1'b0, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tp_dis_loader.md
TP_DIS_LOADER -- requirements
Module: tp_dis_loader

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: start  in  1  begin load (pulse); city_count  in  city_num_log+1  cities N, 2..city_num.
REQ-003 SHALL have ports: running  in  1  annealer active, blocks start; busy  out  1  load in progress; done  out  1  one-cycle completion pulse.
REQ-004 SHALL have ports: s_valid  in  1; s_data  in  64  packed distances; s_ready  out  1  word accepted when s_valid&s_ready.
REQ-005 SHALL have ports: tp_dis_write  out  1; tp_dis_waddr  out  city_num_log*2  {row,col}; tp_dis_wdata  out  distance_data_t.

Function
REQ-006 SHALL take LANES = 64/$bits(distance_data_t) from replica_pkg; a non-integral LANES SHALL be an elaboration error.
REQ-007 SHALL use states IDLE, FETCH, EMIT, DONE.
REQ-008 IDLE->FETCH on start=1 & running=0 & 2<=city_count<=city_num: latch N, row=0, col=0; otherwise start is ignored.
REQ-009 FETCH: s_ready=1; on handshake, latch s_data, lane=0, go to EMIT.
REQ-010 EMIT: each cycle, tp_dis_write=1, wdata=lane[lane] (lane 0 = bits [W-1:0]), waddr={row,col}.
REQ-011 After each write: col++; at col=N-1, col wraps to 0 and row++.
REQ-012 Entries are written row-major over the full N x N matrix, diagonal included; total writes = N*N.
REQ-013 After the last lane of a word: if entries remain, s_ready=1 in that same cycle for back-to-back fetch.
REQ-014 With a word accepted in that cycle, next cycle stays in EMIT at lane 0; without one, go to FETCH.
REQ-015 Sustained valid input SHALL give one write per cycle with no bubbles.
REQ-016 When write N*N issues: unused lanes of that word SHALL be discarded, s_ready=0 that cycle, next state DONE.
REQ-017 DONE lasts one cycle: done=1, then IDLE.
REQ-018 busy=1 in FETCH, EMIT and DONE.
REQ-019 s_ready SHALL be 0 in IDLE and DONE; words offered there are not consumed.
REQ-020 Write latency from word handshake to its lane-0 write SHALL be exactly 1 cycle.
REQ-021 running rising while busy SHALL NOT abort the load; start while busy SHALL be ignored.
REQ-022 row and col SHALL use city_num_log bits each; the N*N counter SHALL be city_num_log*2+1 bits, no overflow at N=city_num.

Reset
REQ-023 On reset=1: state IDLE; busy, done, s_ready, tp_dis_write = 0; waddr and wdata = 0; counters cleared.
REQ-024 Reset mid-load SHALL take effect next edge; partial table content is left as is, no done pulse.

Structure
REQ-025 replica_pkg SHALL hold distance_data_t, city_num, city_num_log and a new loader_state_t enum.
REQ-026 The block SHALL have no sub-modules; the lane buffer is a 64-bit register indexed by a lane counter.
REQ-027 tp_dis_* outputs SHALL be registered and drive the existing node tp_dis_* broadcast directly.

Verification (distance_data_t = 16 bits, LANES = 4)
REQ-028 N=4, 4 words 0x0004_0003_0002_0001 upward, s_valid held 1 -> 16 consecutive writes; waddr {0,0}..{3,3}; wdata 1..16; done at cycle 18 after start.
REQ-029 N=3, 3 words, s_valid held -> 9 writes; word 3 lanes 1..3 discarded; third handshake only; done once.
REQ-030 N=4, s_valid toggled 1-0 each cycle -> 16 writes in order, stalls only in FETCH; no duplicate or lost lanes.
REQ-031 start with running=1, or city_count=1 -> stays IDLE, busy=0, no writes, s_ready=0.
REQ-032 N=4, reset asserted after write 6 -> next cycle IDLE, all outputs 0, no done; later start N=4 -> full 16-write load from {0,0}.
REQ-033 start pulsed again during EMIT -> ignored; write sequence and count unchanged.
